// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: CPU bytes go through a TX FIFO and are serialised as 8N1 on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [15:0] uart_wdata,
  output logic [15:0] uart_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_PRESENT = 1'b1;
`else
  localparam logic PARITY_PRESENT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shreg_q;
  logic             tx_q;

  logic full, empty, bit_end, pop, push_req, push, drop, ctrl_clr;
  logic unused_wdata;

  assign unused_wdata = ^uart_wdata[15:8];

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign bit_end  = (cnt_q == CNT_MAX);
  // The head is taken either from idle or at the very end of a stop bit, so frames run back to back.
  assign pop      = !empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));
  assign push_req = uartcs & uartwrite & (uartaddr == 2'd0);
  assign push     = push_req & (!full | pop);
  assign drop     = push_req & full & !pop;
  assign ctrl_clr = uartcs & uartwrite & (uartaddr == 2'd2) & uart_wdata[0];

  always_comb begin
    count_d = count_q;
    if (push & !pop)
      count_d = count_q + CW'(1);
    else if (pop & !push)
      count_d = count_q - CW'(1);
  end

  // FIFO storage and shift register hold data only, so they carry no reset.
  always_ff @(posedge clock) begin
    if (push)
      mem_q[wr_ptr_q] <= uart_wdata[7:0];
    if (pop)
      shreg_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (drop)
        ovf_q <= 1'b1;
      else if (ctrl_clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            state_q <= S_START;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shreg_q[0];
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= ^shreg_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shreg_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (!empty) begin
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE) | !empty;

  always_comb begin
    uart_rdata = '0;
    if (uartcs & uartread & (uartaddr == 2'd2))
      uart_rdata = {11'b0, PARITY_PRESENT, ovf_q, full, empty, busy};
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: decode table, directed frame sequences and randomized traffic
// checked every cycle against a byte-queue / frame-slot reference model.
module tb_uart_tx_io;

  localparam int C = 4;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int  NB  = 11;
  localparam logic PAR = 1'b1;
`else
  localparam int  NB  = 10;
  localparam logic PAR = 1'b0;
`endif
  localparam int FL = NB * C;
  localparam logic [15:0] ST_IDLE = 16'h0002 | (PAR ? 16'h0010 : 16'h0000);

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        uartcs = 1'b0, uartwrite = 1'b0, uartread = 1'b0;
  logic [1:0]  uartaddr = 2'd0;
  logic [15:0] uart_wdata = 16'h0;
  logic [15:0] uart_rdata;
  logic        tx, busy;

  uart_tx_io #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock(clock), .rst(rst), .uartcs(uartcs), .uartwrite(uartwrite),
    .uartread(uartread), .uartaddr(uartaddr), .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata), .tx(tx), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes plus the byte currently on the wire and its cycle position.
  logic [7:0] mq[$];
  logic [7:0] m_byte = 8'h0;
  int         m_pos = 0;
  bit         m_act = 1'b0;
  bit         m_ovf = 1'b0;

  // Line level of bit slot k of a frame: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR && k == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic m_tx();
    return m_act ? frame_bit(m_byte, m_pos / C) : 1'b1;
  endfunction

  function automatic logic m_busy();
    return m_act || (mq.size() > 0);
  endfunction

  function automatic logic [15:0] m_status();
    return {11'b0, PAR, m_ovf, (mq.size() == D), (mq.size() == 0), m_busy()};
  endfunction

  task automatic model_step();
    int  sz;
    bit  popn, wr_d, wr_c;
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
      return;
    end
    sz   = mq.size();
    popn = (sz > 0) && (!m_act || m_pos == FL - 1);
    wr_d = uartcs && uartwrite && (uartaddr == 2'd0);
    wr_c = uartcs && uartwrite && (uartaddr == 2'd2) && uart_wdata[0];
    if (popn) begin
      m_byte = mq.pop_front();
      m_pos  = 0;
      m_act  = 1'b1;
    end else if (m_act) begin
      if (m_pos == FL - 1) m_act = 1'b0;
      else m_pos++;
    end
    if (wr_d) begin
      if (sz < D || popn) mq.push_back(uart_wdata[7:0]);
      else m_ovf = 1'b1;
    end else if (wr_c) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("tx_model", {15'b0, tx}, {15'b0, m_tx()});
    chk("busy_model", {15'b0, busy}, {15'b0, m_busy()});
  endtask

  task automatic bus_idle();
    uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0;
    uartaddr = 2'd0; uart_wdata = 16'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    uartcs = 1'b1; uartwrite = 1'b1; uartread = 1'b0;
    uartaddr = a; uart_wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_status(input string nm, input logic [15:0] exp);
    uartcs = 1'b1; uartread = 1'b1; uartwrite = 1'b0; uartaddr = 2'd2;
    #1;
    chk(nm, uart_rdata, exp);
    bus_idle();
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    chk(nm, {15'b0, busy}, 16'h0);
  endtask

  // Single frame on an idle line: start from E1, FL cycles, busy falls right after.
  task automatic send_and_check(input logic [7:0] b, input string nm);
    wr(2'd0, {8'h0, b});
    chk({nm, "_busy_rise"}, {15'b0, busy}, 16'h1);
    for (int i = 0; i < FL; i++) begin
      tick();
      chk({nm, "_bit"}, {15'b0, tx}, {15'b0, frame_bit(b, i / C)});
    end
    tick();
    chk({nm, "_busy_fall"}, {15'b0, busy}, 16'h0);
  endtask

  typedef struct {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, ST_IDLE};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 2'd1, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 2'd2, 16'h0000, ST_IDLE};

    bus_idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_tx", {15'b0, tx}, 16'h1);
    chk("reset_busy", {15'b0, busy}, 16'h0);
    chk("reset_rdata", uart_rdata, 16'h0);

    for (int i = 0; i < 7; i++) begin
      uartcs = tbl[i].cs; uartread = tbl[i].rd; uartwrite = tbl[i].wr;
      uartaddr = tbl[i].addr; uart_wdata = tbl[i].wd;
      #1;
      chk($sformatf("decode_vec%0d", i), uart_rdata, tbl[i].exp);
    end
    bus_idle();

    send_and_check(8'h55, "frame55");

    for (int b = 0; b < 10; b++) wr(2'd0, 16'(b));
    rd_status("ovf_full_status", 16'h000D | (PAR ? 16'h0010 : 16'h0000));
    wr(2'd2, 16'h0001);
    rd_status("ovf_cleared_status", 16'h0005 | (PAR ? 16'h0010 : 16'h0000));
    wait_idle(10 * FL + 20, "burst_drain");
    rd_status("burst_idle_status", ST_IDLE);

    wr(2'd0, 16'h00A0);
    wr(2'd0, 16'h000F);
    n = 1;
    while (n < 4 * FL) begin
      tick();
      if (!busy) break;
      n++;
      if (n == FL) chk("b2b_stop1", {15'b0, tx}, 16'h1);
      if (n == FL + 1) chk("b2b_start2", {15'b0, tx}, 16'h0);
    end
    chk("b2b_len", 16'(n), 16'(2 * FL));

    wr(2'd0, 16'h00FF);
    wr(2'd0, 16'h0011);
    wr(2'd0, 16'h0022);
    repeat (16) tick();
    chk("abort_pre_tx", {15'b0, tx}, 16'h1);
    chk("abort_pre_busy", {15'b0, busy}, 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", {15'b0, tx}, 16'h1);
    chk("abort_busy", {15'b0, busy}, 16'h0);
    rd_status("abort_status", ST_IDLE);
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      chk("abort_quiet", {tx, busy}, 16'h2);
    end

`ifdef UART_TX_PARITY_EN
    send_and_check(8'h07, "parity07");
    rd_status("parity_status", ST_IDLE);
`endif

    for (int i = 0; i < 4000; i++) begin
      int  r;
      bit  hot;
      r   = $urandom_range(0, 99);
      hot = ((i / 400) % 2) == 0;
      bus_idle();
      rst = ((i % 997) == 996);
      if (r < (hot ? 45 : 4)) begin
        uartcs = 1'b1; uartwrite = 1'b1; uartaddr = 2'd0;
        uart_wdata = 16'($urandom);
      end else if (r < 52) begin
        uartcs = 1'($urandom_range(0, 1)); uartwrite = 1'b1;
        uartaddr = 2'($urandom_range(0, 3)); uart_wdata = 16'($urandom_range(0, 3));
      end else if (r < 65) begin
        uartcs = 1'b1; uartread = 1'b1; uartaddr = 2'($urandom_range(0, 3));
        #1;
        chk("rand_rdata", uart_rdata, (uartaddr == 2'd2) ? m_status() : 16'h0);
      end
      tick();
    end
    bus_idle();
    rst = 1'b0;
    wait_idle(10 * FL + 20, "rand_drain");
    rd_status("final_status", m_status());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
